ep_in_sched: RTL and testbench

Scheduler that shares the USB endpoint-3 IN buffer between two byte-FIFO requesters: req0 for the TS stream and req1 for the status/aux stream. It owns the buffer address counter, write strobes, commit pulse and commit-ack handshake. Ownership is block-granular: a granted requester keeps the buffer until its block is committed. Partially filled blocks are flushed after an idle timeout. It sits between the TS/aux FIFOs and the USB endpoint buffer.

---
 rtl/ep_in_sched.sv | 179 +++++++++++++++++
 tb/tb_ep_in_sched.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ep_in_sched.sv
// ep_in_sched: shares the EP3 IN buffer between two byte FIFOs with block-granular ownership.
// One byte per 4 cycles; partial blocks are force-committed after FLUSH_TIMEOUT idle cycles.
module ep_in_sched #(
  parameter int ACK_TIMEOUT   = 7,
  parameter int FLUSH_TIMEOUT = 4096,
  parameter int TO_W          = 13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] cfg_commit_len,
  input  logic        req0_empty,
  output logic        req0_rdreq,
  input  logic [7:0]  req0_q,
  input  logic        req1_empty,
  output logic        req1_rdreq,
  input  logic [7:0]  req1_q,
  output logic [10:0] usb_in_addr,
  output logic [7:0]  usb_in_data,
  output logic        usb_in_wren,
  output logic        usb_in_commit,
  output logic [10:0] usb_in_commit_len,
  input  logic        usb_in_ready,
  input  logic        usb_in_commit_ack,
  output logic        stat_owner,
  output logic [15:0] stat_blocks,
  output logic [7:0]  stat_flushes,
  output logic [7:0]  stat_ack_to
);
  localparam int AT_W = $clog2(ACK_TIMEOUT + 2);
  localparam logic [AT_W-1:0] ACK_LAST   = AT_W'(ACK_TIMEOUT - 1);
  localparam logic [TO_W-1:0] FLUSH_LAST = TO_W'(FLUSH_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_NEXT, S_COMMIT, S_WAIT_ACK} state_t;

  state_t            state, state_n;
  logic [10:0]       cnt, cnt_n, len, len_n;
  logic              owner, owner_n, rr, rr_n;
  logic [TO_W-1:0]   ftmr, ftmr_n;
  logic [AT_W-1:0]   atmr, atmr_n;
  logic              ack_1, ack_2;
  logic              rd0_n, rd1_n, wren_n, commit_n;
  logic [10:0]       addr_n, clen_n;
  logic [7:0]        data_n, flushes_n, ack_to_n;
  logic [15:0]       blocks_n;

  logic grant, owner_empty, ack_fall;

  // When both requesters are waiting the round-robin pointer decides.
  assign grant       = req0_empty ? 1'b1 : (req1_empty ? 1'b0 : rr);
  assign owner_empty = owner ? req1_empty : req0_empty;
  assign ack_fall    = ack_2 & ~ack_1;
  assign stat_owner  = owner;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    len_n     = len;
    owner_n   = owner;
    rr_n      = rr;
    ftmr_n    = ftmr;
    atmr_n    = atmr;
    rd0_n     = 1'b0;
    rd1_n     = 1'b0;
    wren_n    = 1'b0;
    commit_n  = 1'b0;
    addr_n    = usb_in_addr;
    data_n    = usb_in_data;
    clen_n    = usb_in_commit_len;
    blocks_n  = stat_blocks;
    flushes_n = stat_flushes;
    ack_to_n  = stat_ack_to;
    case (state)
      S_IDLE: begin
        if (usb_in_ready) begin
          if (cnt == 11'd0) begin
            if (!req0_empty || !req1_empty) begin
              owner_n = grant;
              len_n   = (cfg_commit_len == 11'd0) ? 11'd1 : cfg_commit_len;
              rd0_n   = ~grant;
              rd1_n   = grant;
              ftmr_n  = '0;
              state_n = S_READ;
            end
          end else if (!owner_empty) begin
            rd0_n   = ~owner;
            rd1_n   = owner;
            ftmr_n  = '0;
            state_n = S_READ;
          end else if (ftmr == FLUSH_LAST) begin
            len_n     = cnt;
            flushes_n = stat_flushes + 8'd1;
            state_n   = S_COMMIT;
          end else begin
            ftmr_n = ftmr + 1'b1;
          end
        end
      end
      S_READ: state_n = S_WRITE;
      S_WRITE: begin
        data_n  = owner ? req1_q : req0_q;
        addr_n  = cnt;
        wren_n  = 1'b1;
        state_n = S_NEXT;
      end
      S_NEXT: begin
        if (cnt == len - 11'd1) begin
          state_n = S_COMMIT;
        end else begin
          cnt_n   = cnt + 11'd1;
          state_n = S_IDLE;
        end
      end
      S_COMMIT: begin
        commit_n = 1'b1;
        clen_n   = len;
        cnt_n    = '0;
        atmr_n   = '0;
        ftmr_n   = '0;
        state_n  = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        // A falling edge seen in the same cycle as the timeout still counts as acked.
        if (ack_fall || (atmr > ACK_LAST)) begin
          if (!ack_fall) ack_to_n = stat_ack_to + 8'd1;
          blocks_n = stat_blocks + 16'd1;
          rr_n     = ~owner;
          state_n  = S_IDLE;
        end else begin
          atmr_n = atmr + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      cnt               <= '0;
      len               <= '0;
      owner             <= 1'b0;
      rr                <= 1'b0;
      ftmr              <= '0;
      atmr              <= '0;
      ack_1             <= 1'b0;
      ack_2             <= 1'b0;
      req0_rdreq        <= 1'b0;
      req1_rdreq        <= 1'b0;
      usb_in_addr       <= '0;
      usb_in_data       <= '0;
      usb_in_wren       <= 1'b0;
      usb_in_commit     <= 1'b0;
      usb_in_commit_len <= '0;
      stat_blocks       <= '0;
      stat_flushes      <= '0;
      stat_ack_to       <= '0;
    end else begin
      state             <= state_n;
      cnt               <= cnt_n;
      len               <= len_n;
      owner             <= owner_n;
      rr                <= rr_n;
      ftmr              <= ftmr_n;
      atmr              <= atmr_n;
      ack_1             <= usb_in_commit_ack;
      ack_2             <= ack_1;
      req0_rdreq        <= rd0_n;
      req1_rdreq        <= rd1_n;
      usb_in_addr       <= addr_n;
      usb_in_data       <= data_n;
      usb_in_wren       <= wren_n;
      usb_in_commit     <= commit_n;
      usb_in_commit_len <= clen_n;
      stat_blocks       <= blocks_n;
      stat_flushes      <= flushes_n;
      stat_ack_to       <= ack_to_n;
    end
  end
endmodule

// File: tb/tb_ep_in_sched.sv
// Scoreboard bench for ep_in_sched: a block-level model predicts every buffer write and
// commit, and a negedge monitor compares them as the DUT emits them.
module tb_ep_in_sched;
  localparam int FLUSH_TO = 16;
  localparam int ACK_TO   = 7;

  typedef struct {
    bit          is_commit;
    logic [10:0] val;
    logic [7:0]  data;
    bit          owner;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] cfg_commit_len = 11'd4;
  logic        req0_empty = 1'b1, req1_empty = 1'b1;
  logic        req0_rdreq, req1_rdreq;
  logic [7:0]  req0_q = 8'h00, req1_q = 8'h00;
  logic [10:0] usb_in_addr, usb_in_commit_len;
  logic [7:0]  usb_in_data;
  logic        usb_in_wren, usb_in_commit;
  logic        usb_in_ready = 1'b1;
  logic        usb_in_commit_ack = 1'b0;
  logic        stat_owner;
  logic [15:0] stat_blocks;
  logic [7:0]  stat_flushes, stat_ack_to;

  always #5 clk = ~clk;

  ep_in_sched #(.ACK_TIMEOUT(ACK_TO), .FLUSH_TIMEOUT(FLUSH_TO), .TO_W(13)) dut (
    .clk(clk), .reset(reset), .cfg_commit_len(cfg_commit_len),
    .req0_empty(req0_empty), .req0_rdreq(req0_rdreq), .req0_q(req0_q),
    .req1_empty(req1_empty), .req1_rdreq(req1_rdreq), .req1_q(req1_q),
    .usb_in_addr(usb_in_addr), .usb_in_data(usb_in_data), .usb_in_wren(usb_in_wren),
    .usb_in_commit(usb_in_commit), .usb_in_commit_len(usb_in_commit_len),
    .usb_in_ready(usb_in_ready), .usb_in_commit_ack(usb_in_commit_ack),
    .stat_owner(stat_owner), .stat_blocks(stat_blocks),
    .stat_flushes(stat_flushes), .stat_ack_to(stat_ack_to)
  );

  int         errors = 0;
  int         checks = 0;
  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] fifo0[$], fifo1[$];
  bit         mon_en = 1'b0;
  logic [1:0] rd_hist = 2'b00;
  int         ack_mode = 0;   // 0 prompt ack, 1 withhold next ack only, 2 random
  int         ack_wait = -1;
  int         n_noack = 0;
  int         ack_base = 0;
  int         exp_blocks = 0;
  int         exp_flushes = 0;
  bit         rr_m = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Non-showahead FIFOs: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (req0_rdreq && fifo0.size() > 0) req0_q <= fifo0.pop_front();
    if (req1_rdreq && fifo1.size() > 0) req1_q <= fifo1.pop_front();
    req0_empty <= (fifo0.size() == 0);
    req1_empty <= (fifo1.size() == 0);
  end

  // Host side: ack is a short high pulse a few cycles after each commit, unless withheld.
  always @(negedge clk) begin
    usb_in_commit_ack = (ack_wait == 0);
    if (ack_wait >= 0) ack_wait--;
    if (usb_in_commit) begin
      if (ack_mode == 1 || (ack_mode == 2 && $urandom_range(0, 3) == 0)) begin
        n_noack++;
        if (ack_mode == 1) ack_mode = 0;
      end else begin
        ack_wait = $urandom_range(1, 3);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && (usb_in_wren || usb_in_commit)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {62'd0, usb_in_commit, usb_in_wren}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_kind", {62'd0, usb_in_commit, usb_in_wren}, mon_e.is_commit ? 64'd2 : 64'd1);
        if (!mon_e.is_commit) begin
          check("wr_addr", usb_in_addr, mon_e.val);
          check("wr_data", usb_in_data, mon_e.data);
          check("wr_owner", stat_owner, mon_e.owner);
          check("wren_2_after_rdreq", rd_hist[1], 1);
        end else begin
          check("commit_len", usb_in_commit_len, mon_e.val);
        end
      end
    end
    rd_hist <= {rd_hist[0], req0_rdreq | req1_rdreq};
  end

  // Block-level model: the granted requester supplies up to len bytes; a short block is flushed.
  task automatic plan(input logic [7:0] s0[$], input logic [7:0] s1[$], input int cfg);
    exp_t e;
    bit   g;
    int   len, n;
    len = (cfg == 0) ? 1 : cfg;
    while (s0.size() > 0 || s1.size() > 0) begin
      if (s0.size() == 0) g = 1'b1;
      else if (s1.size() == 0) g = 1'b0;
      else g = rr_m;
      n = 0;
      while (n < len && (g ? s1.size() : s0.size()) > 0) begin
        e.is_commit = 1'b0;
        e.val = 11'(n);
        e.owner = g;
        if (g) e.data = s1.pop_front();
        else e.data = s0.pop_front();
        exp_q.push_back(e);
        n++;
      end
      e.is_commit = 1'b1;
      e.val = 11'(n);
      e.data = 8'h00;
      e.owner = g;
      exp_q.push_back(e);
      exp_blocks++;
      if (n < len) exp_flushes++;
      rr_m = ~g;
    end
  endtask

  task automatic load(input logic [7:0] s0[$], input logic [7:0] s1[$]);
    foreach (s0[i]) fifo0.push_back(s0[i]);
    foreach (s1[i]) fifo1.push_back(s1[i]);
  endtask

  task automatic quiesce(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fifo0.size() != 0 || fifo1.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    repeat (30) @(negedge clk);
    check({name, "_blocks"}, stat_blocks, exp_blocks & 16'hFFFF);
    check({name, "_flushes"}, stat_flushes, exp_flushes & 8'hFF);
    check({name, "_ack_to"}, stat_ack_to, (n_noack - ack_base) & 8'hFF);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] s0[$];
    logic [7:0] s1[$];
    int last, cidx, k, cnt;
    logic [15:0] prev;

    repeat (3) @(negedge clk);
    check("reset_outputs", {req0_rdreq, req1_rdreq, usb_in_addr, usb_in_data, usb_in_wren,
                            usb_in_commit, usb_in_commit_len, stat_owner}, 0);
    check("reset_stats", {stat_blocks, stat_flushes, stat_ack_to}, 0);
    reset = 1'b0;
    mon_en = 1'b1;

    // Single block from req0; a cfg change mid-block must not alter its length.
    cfg_commit_len = 11'd4;
    s0 = {}; s1 = {};
    for (int i = 0; i < 4; i++) s0.push_back(8'hA0 + 8'(i));
    plan(s0, s1, 4);
    load(s0, s1);
    for (int i = 0; i < 50 && !req0_rdreq; i++) @(negedge clk);
    cfg_commit_len = 11'd2;
    quiesce("single");

    // Both requesters full: blocks alternate and never mix sources.
    cfg_commit_len = 11'd4;
    s0 = {}; s1 = {};
    for (int i = 0; i < 8; i++) begin
      s0.push_back(8'h10 + 8'(i));
      s1.push_back(8'h80 + 8'(i));
    end
    plan(s0, s1, 4);
    load(s0, s1);
    quiesce("alternate");

    // Partial block: idle flush after FLUSH_TO idle cycles following the READ/WRITE/NEXT of the last byte.
    cfg_commit_len = 11'd10;
    s0 = {}; s1 = {};
    for (int i = 0; i < 3; i++) s0.push_back(8'($urandom));
    plan(s0, s1, 10);
    load(s0, s1);
    last = -1; cidx = -1;
    for (int i = 0; i < 400 && cidx < 0; i++) begin
      @(negedge clk);
      if (req0_rdreq) last = i;
      if (usb_in_commit) cidx = i;
    end
    check("flush_latency", cidx - last, 3 + FLUSH_TO + 1);
    quiesce("flush");

    // Withheld ack: the first commit times out, the second block completes normally.
    cfg_commit_len = 11'd2;
    ack_mode = 1;
    s0 = {}; s1 = {};
    for (int i = 0; i < 4; i++) s1.push_back(8'($urandom));
    plan(s0, s1, 2);
    load(s0, s1);
    for (int i = 0; i < 200 && !usb_in_commit; i++) @(negedge clk);
    prev = stat_blocks;
    k = 0;
    while (stat_blocks == prev && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("ack_timeout_exit", k, ACK_TO + 1);
    quiesce("ack_timeout");

    // Buffer not ready mid-block: no reads and no flush while it is low.
    cfg_commit_len = 11'd4;
    s0 = {}; s1 = {};
    for (int i = 0; i < 4; i++) s0.push_back(8'($urandom));
    plan(s0, s1, 4);
    fifo0.push_back(s0[0]);
    fifo0.push_back(s0[1]);
    k = 0;
    for (int i = 0; i < 100 && k < 2; i++) begin
      @(negedge clk);
      if (usb_in_wren) k++;
    end
    usb_in_ready = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (req0_rdreq || req1_rdreq || usb_in_commit) cnt++;
      if (i == 100) begin
        fifo0.push_back(s0[2]);
        fifo0.push_back(s0[3]);
      end
    end
    check("ready_low_activity", cnt, 0);
    usb_in_ready = 1'b1;
    quiesce("ready_drop");

    // Reset during the WRITE of byte 2 discards the block; the model restarts from reset state.
    mon_en = 1'b0;
    cfg_commit_len = 11'd4;
    s0 = {}; s1 = {};
    for (int i = 0; i < 4; i++) begin
      s0.push_back(8'($urandom));
      s1.push_back(8'($urandom));
    end
    load(s0, s1);
    k = 0;
    for (int i = 0; i < 100 && k < 3; i++) begin
      @(negedge clk);
      if (req0_rdreq || req1_rdreq) k++;
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_outputs", {req0_rdreq, req1_rdreq, usb_in_addr, usb_in_data, usb_in_wren,
                                usb_in_commit, usb_in_commit_len, stat_owner}, 0);
    check("reset_mid_stats", {stat_blocks, stat_flushes, stat_ack_to}, 0);
    reset = 1'b0;
    exp_q.delete();
    rr_m = 1'b0;
    exp_blocks = 0;
    exp_flushes = 0;
    ack_base = n_noack;
    s0 = fifo0;
    s1 = fifo1;
    plan(s0, s1, 4);
    mon_en = 1'b1;
    quiesce("after_reset");

    // Zero length means single-byte blocks.
    cfg_commit_len = 11'd0;
    s0 = {}; s1 = {};
    for (int i = 0; i < 3; i++) s0.push_back(8'($urandom));
    for (int i = 0; i < 2; i++) s1.push_back(8'($urandom));
    plan(s0, s1, 0);
    load(s0, s1);
    quiesce("len_zero");

    // Randomized rounds: random lengths, fill levels and ack behaviour.
    ack_mode = 2;
    for (int r = 0; r < 6; r++) begin
      int c;
      c = $urandom_range(0, 6);
      cfg_commit_len = 11'(c);
      s0 = {}; s1 = {};
      for (int i = 0; i < int'($urandom_range(0, 10)); i++) s0.push_back(8'($urandom));
      for (int i = 0; i < int'($urandom_range(0, 10)); i++) s1.push_back(8'($urandom));
      plan(s0, s1, c);
      load(s0, s1);
      quiesce("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
